// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIF extension: ID sizing, issuer FSM states and
// the issue/commit payload structs.
package fir_xifu_pkg;

    localparam int X_ID_WIDTH = 4;
    localparam int X_ID_MAX   = 16;
    // Wide enough to hold 0..X_ID_MAX outstanding IDs.
    localparam int CNT_W      = 5;

    typedef logic [X_ID_WIDTH-1:0] xid_t;

    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_ISSUE,
        ISS_COMMIT
    } issuer_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        xid_t        id;
    } issue_req_t;

    typedef struct packed {
        xid_t id;
        logic kill;
    } commit_t;

endpackage

// File: rtl/fir_xif_id_tracker.sv
// In-order XIF ID allocator: next_id counter, outstanding bitmap, in-flight
// count and sticky error for results that arrive for an ID not in flight.
module fir_xif_id_tracker
    import fir_xifu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             advance_i,
    input  logic             set_i,
    input  logic             clr_valid_i,
    input  xid_t             clr_id_i,
    output xid_t             next_id_o,
    output logic             can_alloc_o,
    output logic             clr_hit_o,
    output logic [CNT_W-1:0] count_o,
    output logic             error_o
);

    logic [X_ID_MAX-1:0] bitmap_q, bitmap_d;
    xid_t                next_id_q, next_id_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                error_q, error_d;
    logic                clr_hit;

    always_comb begin
        bitmap_d  = bitmap_q;
        next_id_d = next_id_q;
        error_d   = error_q;
        clr_hit   = clr_valid_i & bitmap_q[clr_id_i];
        if (clr_hit) begin
            bitmap_d[clr_id_i] = 1'b0;
        end else if (clr_valid_i) begin
            error_d = 1'b1;
        end
        // The ID being set is never busy (checked before issue), so set and
        // clear never collide on the same bit.
        if (set_i) begin
            bitmap_d[next_id_q] = 1'b1;
        end
        if (advance_i) begin
            next_id_d = next_id_q + xid_t'(1);
        end
        count_d = count_q + CNT_W'(set_i) - CNT_W'(clr_hit);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bitmap_q  <= '0;
            next_id_q <= '0;
            count_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            bitmap_q  <= bitmap_d;
            next_id_q <= next_id_d;
            count_q   <= count_d;
            error_q   <= error_d;
        end
    end

    assign next_id_o   = next_id_q;
    assign can_alloc_o = !bitmap_q[next_id_q] && (count_q < CNT_W'(MAX_OUTSTANDING));
    assign clr_hit_o   = clr_hit;
    assign count_o     = count_q;
    assign error_o     = error_q;

endmodule

// File: rtl/fir_xif_issuer.sv
// Core-side XIF initiator: issue -> commit sequencing with in-order IDs and
// result retirement into the RF write port. FIR_XIF_ISSUER_PERF_EN adds counters.
module fir_xif_issuer
    import fir_xifu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_val_i,
    input  logic [31:0] rs2_val_i,
    input  logic        kill_i,
    output logic        issue_valid_o,
    input  logic        issue_ready_i,
    output logic [31:0] issue_instr_o,
    output logic [63:0] issue_rs_o,
    output logic [3:0]  issue_id_o,
    input  logic        issue_accept_i,
    input  logic        issue_writeback_i,
    output logic        commit_valid_o,
    output logic [3:0]  commit_id_o,
    output logic        commit_kill_o,
    input  logic        result_valid_i,
    output logic        result_ready_o,
    input  logic [3:0]  result_id_i,
    input  logic [4:0]  result_rd_i,
    input  logic [31:0] result_data_i,
    input  logic        result_we_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    input  logic        rf_gnt_i,
    output logic        rejected_o,
    output logic        error_o,
    output logic [4:0]  outstanding_o,
    output logic [31:0] perf_issued_o,
    output logic [31:0] perf_rejected_o,
    output logic [31:0] perf_stall_o
);

    // Handshakes: a transfer happens in a cycle where valid && ready; once
    // issue_valid_o rises, it and the payload hold until issue_ready_i.
    issuer_state_t    state_q;
    issue_req_t       req_q;
    logic             issue_valid_q, commit_valid_q, accept_q, wb_q;
    logic             issue_hs, result_hs, set_en, can_alloc, clr_hit;
    xid_t             next_id;
    logic [CNT_W-1:0] count;
    commit_t          commit_s;

    assign issue_hs  = issue_valid_q & issue_ready_i;
    assign set_en    = commit_valid_q & accept_q & wb_q & ~kill_i;
    assign result_hs = result_valid_i & result_ready_o;

    fir_xif_id_tracker #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_tracker (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .advance_i   (commit_valid_q),
        .set_i       (set_en),
        .clr_valid_i (result_hs),
        .clr_id_i    (result_id_i),
        .next_id_o   (next_id),
        .can_alloc_o (can_alloc),
        .clr_hit_o   (clr_hit),
        .count_o     (count),
        .error_o     (error_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ISS_IDLE;
            req_q          <= '0;
            issue_valid_q  <= 1'b0;
            commit_valid_q <= 1'b0;
            accept_q       <= 1'b0;
            wb_q           <= 1'b0;
        end else begin
            case (state_q)
                ISS_IDLE: begin
                    if (instr_valid_i && can_alloc) begin
                        req_q.instr   <= instr_i;
                        req_q.rs1     <= rs1_val_i;
                        req_q.rs2     <= rs2_val_i;
                        req_q.id      <= next_id;
                        issue_valid_q <= 1'b1;
                        state_q       <= ISS_ISSUE;
                    end
                end
                ISS_ISSUE: begin
                    if (issue_ready_i) begin
                        accept_q       <= issue_accept_i;
                        wb_q           <= issue_writeback_i;
                        issue_valid_q  <= 1'b0;
                        commit_valid_q <= 1'b1;
                        state_q        <= ISS_COMMIT;
                    end
                end
                ISS_COMMIT: begin
                    commit_valid_q <= 1'b0;
                    state_q        <= ISS_IDLE;
                end
                default: begin
                    issue_valid_q  <= 1'b0;
                    commit_valid_q <= 1'b0;
                    state_q        <= ISS_IDLE;
                end
            endcase
        end
    end

    // kill_i only matters in the commit cycle; a rejected issue is always killed.
    assign commit_s.id   = req_q.id;
    assign commit_s.kill = commit_valid_q & (kill_i | ~accept_q);

    assign instr_ready_o  = issue_hs;
    assign issue_valid_o  = issue_valid_q;
    assign issue_instr_o  = req_q.instr;
    assign issue_rs_o     = {req_q.rs2, req_q.rs1};
    assign issue_id_o     = req_q.id;
    assign commit_valid_o = commit_valid_q;
    assign commit_id_o    = commit_s.id;
    assign commit_kill_o  = commit_s.kill;
    assign rejected_o     = commit_valid_q & ~accept_q;
    assign outstanding_o  = count;

    assign result_ready_o = ~result_we_i | rf_gnt_i;
    assign rf_we_o        = clr_hit & result_we_i;
    assign rf_waddr_o     = rf_we_o ? result_rd_i : 5'd0;
    assign rf_wdata_o     = rf_we_o ? result_data_i : 32'd0;

`ifdef FIR_XIF_ISSUER_PERF_EN
    logic [31:0] perf_issued_q, perf_rejected_q, perf_stall_q;
    logic        stall;

    assign stall = ((state_q == ISS_IDLE) && instr_valid_i && !can_alloc) ||
                   ((state_q == ISS_ISSUE) && !issue_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_issued_q   <= '0;
            perf_rejected_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            if (issue_hs)   perf_issued_q   <= perf_issued_q + 32'd1;
            if (rejected_o) perf_rejected_q <= perf_rejected_q + 32'd1;
            if (stall)      perf_stall_q    <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued_o   = perf_issued_q;
    assign perf_rejected_o = perf_rejected_q;
    assign perf_stall_o    = perf_stall_q;
`else
    assign perf_issued_o   = 32'h0;
    assign perf_rejected_o = 32'h0;
    assign perf_stall_o    = 32'h0;
`endif

endmodule

// File: tb/tb_fir_xif_issuer.sv
// Directed bench for fir_xif_issuer: drives offload transactions and results,
// checks against an ID/outstanding model and hand-computed literals.
module tb_fir_xif_issuer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [31:0] instr_i = '0;
    logic [31:0] rs1_val_i = '0;
    logic [31:0] rs2_val_i = '0;
    logic        kill_i = 1'b0;
    logic        issue_valid_o;
    logic        issue_ready_i = 1'b0;
    logic [31:0] issue_instr_o;
    logic [63:0] issue_rs_o;
    logic [3:0]  issue_id_o;
    logic        issue_accept_i = 1'b0;
    logic        issue_writeback_i = 1'b0;
    logic        commit_valid_o;
    logic [3:0]  commit_id_o;
    logic        commit_kill_o;
    logic        result_valid_i = 1'b0;
    logic        result_ready_o;
    logic [3:0]  result_id_i = '0;
    logic [4:0]  result_rd_i = '0;
    logic [31:0] result_data_i = '0;
    logic        result_we_i = 1'b1;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_gnt_i = 1'b0;
    logic        rejected_o;
    logic        error_o;
    logic [4:0]  outstanding_o;
    logic [31:0] perf_issued_o, perf_rejected_o, perf_stall_o;

    fir_xif_issuer #(.MAX_OUTSTANDING(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_i(instr_i), .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i),
        .kill_i(kill_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_instr_o(issue_instr_o), .issue_rs_o(issue_rs_o), .issue_id_o(issue_id_o),
        .issue_accept_i(issue_accept_i), .issue_writeback_i(issue_writeback_i),
        .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
        .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
        .result_id_i(result_id_i), .result_rd_i(result_rd_i), .result_data_i(result_data_i),
        .result_we_i(result_we_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_gnt_i(rf_gnt_i),
        .rejected_o(rejected_o), .error_o(error_o), .outstanding_o(outstanding_o),
        .perf_issued_o(perf_issued_o), .perf_rejected_o(perf_rejected_o), .perf_stall_o(perf_stall_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model and bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit m_bm[16];
    int m_count = 0;
    bit m_err   = 1'b0;
    int m_next  = 0;
    bit cmp_en  = 1'b0;
    logic [3:0] last_id;
    logic [3:0] got_ids[17];

    localparam logic [31:0] XFIRDOTP = 32'h0220_F2AB;
    localparam logic [31:0] XFIRLW   = 32'h0000_A00B;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_bm[i]) m_bm[i] = 1'b0;
        m_count = 0;
        m_err   = 1'b0;
        m_next  = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".instr_ready"},  instr_ready_o,   0);
        check({tag, ".issue_valid"},  issue_valid_o,   0);
        check({tag, ".issue_instr"},  issue_instr_o,   0);
        check({tag, ".issue_rs"},     issue_rs_o,      0);
        check({tag, ".issue_id"},     issue_id_o,      0);
        check({tag, ".commit_valid"}, commit_valid_o,  0);
        check({tag, ".commit_id"},    commit_id_o,     0);
        check({tag, ".commit_kill"},  commit_kill_o,   0);
        check({tag, ".result_ready"}, result_ready_o,  0);
        check({tag, ".rf_we"},        rf_we_o,         0);
        check({tag, ".rf_waddr"},     rf_waddr_o,      0);
        check({tag, ".rf_wdata"},     rf_wdata_o,      0);
        check({tag, ".rejected"},     rejected_o,      0);
        check({tag, ".error"},        error_o,         0);
        check({tag, ".outstanding"},  outstanding_o,   0);
        check({tag, ".perf_issued"},  perf_issued_o,   0);
        check({tag, ".perf_rejected"}, perf_rejected_o, 0);
        check({tag, ".perf_stall"},   perf_stall_o,    0);
    endtask

    // Continuous scoreboard: in-flight count and sticky error every cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            if (cmp_en && rst_ni) begin
                check("outstanding", outstanding_o, m_count);
                check("error_sticky", error_o, m_err);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_instr(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                            input bit acc, input bit wb, input bit kl, input int delay);
        int exp_id;
        int waited;
        exp_id = m_next;
        waited = 0;
        @(negedge clk_i);
        instr_valid_i = 1'b1;
        instr_i = instr; rs1_val_i = rs1; rs2_val_i = rs2;
        issue_ready_i = 1'b0; kill_i = 1'b0;
        do begin
            @(negedge clk_i);
            waited++;
        end while (!issue_valid_o && waited < 10);
        check("issue_valid_rise", issue_valid_o, 1);
        if (!issue_valid_o) begin
            instr_valid_i = 1'b0;
            return;
        end
        for (int i = 0; i < delay; i++) begin
            check("stall_valid", issue_valid_o, 1);
            check("stall_instr", issue_instr_o, instr);
            check("stall_rs",    issue_rs_o, {rs2, rs1});
            check("stall_id",    issue_id_o, exp_id);
            check("stall_ready", instr_ready_o, 0);
            @(negedge clk_i);
        end
        issue_ready_i = 1'b1; issue_accept_i = acc; issue_writeback_i = wb;
        #1;
        check("hs_valid", issue_valid_o, 1);
        check("hs_instr", issue_instr_o, instr);
        check("hs_rs",    issue_rs_o, {rs2, rs1});
        check("hs_id",    issue_id_o, exp_id);
        check("hs_instr_ready", instr_ready_o, 1);
        check("hs_no_commit", commit_valid_o, 0);
        @(negedge clk_i);
        issue_ready_i = 1'b0; instr_valid_i = 1'b0;
        issue_accept_i = 1'b0; issue_writeback_i = 1'b0;
        kill_i = kl;
        #1;
        check("commit_valid", commit_valid_o, 1);
        check("commit_id",    commit_id_o, exp_id);
        check("commit_kill",  commit_kill_o, kl | !acc);
        check("rejected",     rejected_o, !acc);
        check("post_hs_valid", issue_valid_o, 0);
        check("post_hs_ready", instr_ready_o, 0);
        last_id = commit_id_o;
        @(posedge clk_i);
        if (acc && wb && !kl) begin
            m_bm[exp_id] = 1'b1;
            m_count++;
        end
        m_next = (m_next + 1) % 16;
        #1 kill_i = 1'b0;
    endtask

    task automatic do_result(input int id, input logic [4:0] rd, input logic [31:0] data,
                             input bit we, input bit gnt);
        bit hit;
        bit hs;
        @(negedge clk_i);
        hit = m_bm[id];
        hs  = !we || gnt;
        result_valid_i = 1'b1; result_id_i = id[3:0]; result_rd_i = rd;
        result_data_i = data; result_we_i = we; rf_gnt_i = gnt;
        #1;
        check("result_ready", result_ready_o, hs);
        check("rf_we", rf_we_o, hs && we && hit);
        if (hs && we && hit) begin
            check("rf_waddr", rf_waddr_o, rd);
            check("rf_wdata", rf_wdata_o, data);
        end
        @(posedge clk_i);
        if (hs) begin
            if (hit) begin
                m_bm[id] = 1'b0;
                m_count--;
            end else begin
                m_err = 1'b1;
            end
        end
        #1;
        result_valid_i = 1'b0; result_we_i = 1'b1; rf_gnt_i = 1'b0;
    endtask

    task automatic check_blocked(input int cycles);
        @(negedge clk_i);
        instr_valid_i = 1'b1; instr_i = XFIRLW;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            check("blocked_valid", issue_valid_o, 0);
            check("blocked_ready", instr_ready_o, 0);
        end
        instr_valid_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int id;
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        cmp_en = 1'b1;

        // Single xfirdotp; result first without RF grant, then granted.
        do_instr(XFIRDOTP, 32'h0000_0011, 32'h0000_0022, 1, 1, 0, 0);
        check("t1_commit_id_lit", last_id, 4'd0);
        check("t1_outstanding_lit", outstanding_o, 5'd1);
        do_result(0, 5'd5, 32'h1234, 1, 0);
        do_result(0, 5'd5, 32'h1234, 1, 1);

        // Issue stalled 3 cycles, then a result with no RF write.
        do_instr(XFIRLW, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1, 1, 0, 3);
        check("t2_commit_id_lit", last_id, 4'd1);
        do_result(1, 5'd9, 32'h5555, 0, 0);

        // Rejected issue, then a killed accepted issue.
        do_instr(XFIRLW, 32'h1, 32'h2, 0, 1, 0, 1);
        check("t3_outstanding_lit", outstanding_o, 5'd0);
        do_instr(XFIRDOTP, 32'h3, 32'h4, 1, 1, 1, 0);
        check("t4_outstanding_lit", outstanding_o, 5'd0);

        // Asynchronous reset while an issue request is pending.
        @(negedge clk_i);
        instr_valid_i = 1'b1; instr_i = XFIRDOTP; rs1_val_i = 32'h77; rs2_val_i = 32'h88;
        @(negedge clk_i);
        check("midrst_pre_valid", issue_valid_o, 1);
        result_we_i = 1'b1; rf_gnt_i = 1'b0;
        #2 rst_ni = 1'b0;
        model_reset();
        #1;
        check_all_zero("midrst");
        instr_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fill to MAX_OUTSTANDING, confirm the 9th is held, free id3.
        for (int k = 0; k < 8; k++) begin
            do_instr(XFIRDOTP, 32'(k), 32'(k * 3), 1, 1, 0, k % 2);
        end
        check("full_outstanding_lit", outstanding_o, 5'd8);
        check_blocked(4);
        do_result(3, 5'd3, 32'h3333_0003, 1, 1);
        do_instr(XFIRDOTP, 32'hAA, 32'hBB, 1, 1, 0, 0);
        check("ninth_id_lit", last_id, 4'd8);
        foreach (got_ids[i]) got_ids[i] = '0;
        for (int k = 0; k <= 8; k++) begin
            if (k != 3) do_result(k, 5'(k + 10), 32'hB000 + 32'(k), 1, 1);
        end
        check("drained_lit", outstanding_o, 5'd0);

        // 17 accept/result pairs starting at id9: wraps 15 -> 0.
        for (int k = 0; k < 17; k++) begin
            id = m_next;
            do_instr(XFIRLW, 32'hA000 + 32'(k), 32'hC000 + 32'(k), 1, 1, 0, 0);
            got_ids[k] = last_id;
            do_result(id, 5'(k + 1), 32'hD000 + 32'(k), 1, 1);
        end
        check("wrap_id15", got_ids[6], 4'd15);
        check("wrap_id0",  got_ids[7], 4'd0);
        check("wrap_last", got_ids[16], 4'd9);

        // Result for an idle ID: error, no RF write; error stays set.
        do_result(7, 5'd7, 32'hBAD0_0007, 1, 1);
        repeat (3) @(negedge clk_i);
        check("error_lit", error_o, 1);
        do_instr(XFIRDOTP, 32'h5, 32'h6, 1, 1, 0, 0);
        check("after_err_id_lit", last_id, 4'd10);
        do_result(10, 5'd12, 32'h0000_ABCD, 1, 1);
        check("error_sticky_lit", error_o, 1);

        repeat (2) @(negedge clk_i);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
